// File: rtl/cache_tag_store_pkg.sv
// Shared definitions for the cache tag store: default geometry and sequencer states.
package cache_definition;

    localparam int CACHE_INDEX_W = 10;
    localparam int CACHE_TAG_W   = 18;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        FLUSH = 2'd2
    } tag_store_state_e;

endpackage

// File: rtl/cache_tag_store_if.sv
// Request/response, flush and status signals of the tag store; rsp_perr exists only with CACHE_TAG_PARITY_EN.
interface cache_tag_store_if
    import cache_definition::*;
#(
    parameter int INDEX_W = CACHE_INDEX_W,
    parameter int TAG_W   = CACHE_TAG_W
) ();

    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               req_vbit;
    logic               req_dirty;
    logic               rsp_valid;
    logic [TAG_W-1:0]   rsp_tag;
    logic               rsp_vbit;
    logic               rsp_dirty;
    logic               rsp_hit;
`ifdef CACHE_TAG_PARITY_EN
    logic               rsp_perr;
`endif
    logic               flush_req;
    logic               flush_done;
    logic               busy;

    modport master (
        output req_valid, req_we, req_index, req_tag, req_vbit, req_dirty, flush_req,
        input  req_ready, rsp_valid, rsp_tag, rsp_vbit, rsp_dirty, rsp_hit,
`ifdef CACHE_TAG_PARITY_EN
        input  rsp_perr,
`endif
        input  flush_done, busy
    );

    modport slave (
        input  req_valid, req_we, req_index, req_tag, req_vbit, req_dirty, flush_req,
        output req_ready, rsp_valid, rsp_tag, rsp_vbit, rsp_dirty, rsp_hit,
`ifdef CACHE_TAG_PARITY_EN
        output rsp_perr,
`endif
        output flush_done, busy
    );

endinterface

// File: rtl/cache_tag_ram.sv
// Single-port synchronous tag RAM, 1-cycle read latency; read data register holds between reads.
module cache_tag_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Only the output register is reset, so the response fields start at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cache_tag_store.sv
// Direct-mapped tag store with invalidate-all sequencer (reset and flush); reads respond after 1 cycle.
// req_ready is low while sweeping; optional parity check under CACHE_TAG_PARITY_EN.
module cache_tag_store
    import cache_definition::*;
#(
    parameter int INDEX_W = CACHE_INDEX_W,
    parameter int TAG_W   = CACHE_TAG_W
) (
    input logic              clk,
    input logic              rst_n,
    cache_tag_store_if.slave bus
);

`ifdef CACHE_TAG_PARITY_EN
    localparam int ENTRY_W = TAG_W + 3;
`else
    localparam int ENTRY_W = TAG_W + 2;
`endif

    tag_store_state_e   state;
    tag_store_state_e   state_nxt;
    logic [INDEX_W-1:0] sweep_cnt;
    logic               pending;
    logic               flush_done_q;
    logic               rsp_valid_q;
    logic [TAG_W-1:0]   cmp_tag_q;
    logic               sweeping;
    logic               sweep_last;
    logic               accept;
    logic               rd_accept;
    logic               ram_en;
    logic               ram_we;
    logic [INDEX_W-1:0] ram_addr;
    logic [ENTRY_W-1:0] ram_wdata;
    logic [ENTRY_W-1:0] ram_rdata;
    logic [ENTRY_W-1:0] wr_entry;
    logic               tag_match;

    assign sweeping   = (state != IDLE);
    assign sweep_last = sweeping && (sweep_cnt == '1);
    assign accept     = bus.req_valid && (state == IDLE);
    assign rd_accept  = accept && !bus.req_we;

`ifdef CACHE_TAG_PARITY_EN
    assign wr_entry = {^{bus.req_tag, bus.req_vbit, bus.req_dirty},
                       bus.req_tag, bus.req_vbit, bus.req_dirty};
`else
    assign wr_entry = {bus.req_tag, bus.req_vbit, bus.req_dirty};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush arriving on the final sweep cycle counts as pending, so it is never lost.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT, FLUSH: begin
                if (sweep_last) begin
                    state_nxt = (pending || bus.flush_req) ? FLUSH : IDLE;
                end
            end
            IDLE: begin
                if (bus.flush_req) begin
                    state_nxt = FLUSH;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = bus.req_index;
        ram_wdata = '0;
        case (state)
            IDLE: begin
                ram_en    = accept;
                ram_we    = bus.req_we;
                ram_wdata = wr_entry;
            end
            default: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = sweep_cnt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt    <= '0;
            pending      <= 1'b0;
            flush_done_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            cmp_tag_q    <= '0;
        end else begin
            sweep_cnt    <= sweeping ? sweep_cnt + 1'b1 : '0;
            pending      <= sweeping && !sweep_last && (pending || bus.flush_req);
            flush_done_q <= (state == FLUSH) && sweep_last;
            rsp_valid_q  <= rd_accept;
            if (rd_accept) begin
                cmp_tag_q <= bus.req_tag;
            end
        end
    end

    cache_tag_ram #(
        .ADDR_W (INDEX_W),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign tag_match      = (ram_rdata[TAG_W+1:2] == cmp_tag_q);
    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = sweeping;
    assign bus.flush_done = flush_done_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_tag    = ram_rdata[TAG_W+1:2];
    assign bus.rsp_vbit   = ram_rdata[1];
    assign bus.rsp_dirty  = ram_rdata[0];

`ifdef CACHE_TAG_PARITY_EN
    assign bus.rsp_perr = ^ram_rdata;
    assign bus.rsp_hit  = ram_rdata[1] && tag_match && !(^ram_rdata);
`else
    assign bus.rsp_hit  = ram_rdata[1] && tag_match;
`endif

endmodule
